decode_stage: RTL and testbench

Instruction decode stage of the 8-bit RISC-V pipeline. It sits between the IF/ID register and EX, and drives the register file's read addresses. The register file read is registered (one-cycle latency), so the block holds the decoded control in its own registers and aligns it with the returned read data. Together these form the ID/EX boundary. The block also detects load-use hazards, bypasses same-edge writebacks, and handles EX backpressure and branch flushes.

---
 rtl/decode_stage.sv | 243 ++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode for the 8-bit pipeline; owns the ID/EX register.
// Optional WB_BYPASS_EN: same-edge writeback bypass instead of a WB hazard stall.
module decode_stage #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [31:0]       if_instr,
  output logic              if_ready,
  input  logic              flush,
  output logic [REG_AW-1:0] rf_read_reg1,
  output logic [REG_AW-1:0] rf_read_reg2,
  input  logic [DATA_W-1:0] rf_read_data1,
  input  logic [DATA_W-1:0] rf_read_data2,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_write_reg,
  input  logic [DATA_W-1:0] wb_write_data,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_rs1_data,
  output logic [DATA_W-1:0] ex_rs2_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [3:0]        ex_alu_op,
  output logic [2:0]        ex_funct3,
  output logic              ex_alu_src,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_reg_write,
  output logic              ex_branch,
  output logic              illegal
);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] imm;
    logic [3:0]        alu_op;
    logic [2:0]        funct3;
    logic              alu_src;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic              branch;
  } id_ex_t;

  id_ex_t            dec;
  id_ex_t            ex_d;
  id_ex_t            ex_q;
  logic              illegal_d;
  logic              illegal_q;
  logic [6:0]        opc;
  logic [2:0]        f3;
  logic              sub_b;
  logic              is_r;
  logic              is_i;
  logic              is_ld;
  logic              is_st;
  logic              is_br;
  logic              legal;
  logic              uses_rs2;
  logic [REG_AW-1:0] rs1_f;
  logic [REG_AW-1:0] rs2_f;
  logic [REG_AW-1:0] rd_f;
  logic [31:0]       imm_i;
  logic [31:0]       imm_s;
  logic [31:0]       imm_b;
  logic              adv;
  logic              hz_lu;
  logic              hz;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;

  assign opc   = if_instr[6:0];
  assign f3    = if_instr[14:12];
  assign sub_b = if_instr[30];
  assign rs1_f = if_instr[15 +: REG_AW];
  assign rs2_f = if_instr[20 +: REG_AW];
  assign rd_f  = if_instr[7 +: REG_AW];

  assign is_r  = (opc == OP_R);
  assign is_i  = (opc == OP_I);
  assign is_ld = (opc == OP_LD);
  assign is_st = (opc == OP_ST);
  assign is_br = (opc == OP_BR);
  assign legal = is_r | is_i | is_ld | is_st | is_br;
  assign uses_rs2 = is_r | is_st | is_br;

  assign imm_i = {{20{if_instr[31]}}, if_instr[31:20]};
  assign imm_s = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
  assign imm_b = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                  if_instr[30:25], if_instr[11:8], 1'b0};

  always_comb begin
    dec        = '0;
    dec.rs1    = rs1_f;
    dec.rs2    = rs2_f;
    dec.funct3 = f3;
    unique case (1'b1)
      is_r: begin
        dec.rd        = rd_f;
        dec.alu_op    = {sub_b, f3};
        dec.reg_write = 1'b1;
      end
      is_i: begin
        dec.rd        = rd_f;
        dec.imm       = DATA_W'(imm_i);
        dec.alu_op    = {sub_b & (f3 == 3'b101), f3};
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
      end
      is_ld: begin
        dec.rd        = rd_f;
        dec.imm       = DATA_W'(imm_i);
        dec.alu_src   = 1'b1;
        dec.mem_read  = 1'b1;
        dec.reg_write = 1'b1;
      end
      is_st: begin
        dec.imm       = DATA_W'(imm_s);
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
      end
      is_br: begin
        dec.imm    = DATA_W'(imm_b);
        dec.alu_op = 4'b1000;
        dec.branch = 1'b1;
      end
      default: ;
    endcase
  end

  assign adv   = !ex_q.valid || ex_ready;
  assign hz_lu = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) &&
                 ((ex_q.rd == rs1_f) || ((ex_q.rd == rs2_f) && uses_rs2));

`ifdef WB_BYPASS_EN
  logic              hit1_d;
  logic              hit1_q;
  logic              hit2_d;
  logic              hit2_q;
  logic [DATA_W-1:0] byp1_d;
  logic [DATA_W-1:0] byp1_q;
  logic [DATA_W-1:0] byp2_d;
  logic [DATA_W-1:0] byp2_q;

  assign hz = hz_lu;

  // RF read is not write-first, so catch the write landing on the read edge
  always_comb begin
    hit1_d = wb_reg_write && (wb_write_reg != '0) &&
             (wb_write_reg == rf_read_reg1);
    hit2_d = wb_reg_write && (wb_write_reg != '0) &&
             (wb_write_reg == rf_read_reg2);
    byp1_d = hit1_d ? wb_write_data : byp1_q;
    byp2_d = hit2_d ? wb_write_data : byp2_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hit1_q <= 1'b0;
      hit2_q <= 1'b0;
      byp1_q <= '0;
      byp2_q <= '0;
    end else begin
      hit1_q <= hit1_d;
      hit2_q <= hit2_d;
      byp1_q <= byp1_d;
      byp2_q <= byp2_d;
    end
  end

  assign op1 = hit1_q ? byp1_q : rf_read_data1;
  assign op2 = hit2_q ? byp2_q : rf_read_data2;
`else
  logic hz_wb;
  logic unused_wb;

  // without a bypass, hold one cycle so the re-read sees the new value
  assign hz_wb = wb_reg_write && (wb_write_reg != '0) &&
                 (((wb_write_reg == rs1_f) && legal) ||
                  ((wb_write_reg == rs2_f) && uses_rs2));
  assign hz        = hz_lu || hz_wb;
  assign unused_wb = ^wb_write_data;
  assign op1       = rf_read_data1;
  assign op2       = rf_read_data2;
`endif

  assign if_ready     = adv && !hz;
  assign rf_read_reg1 = adv ? rs1_f : ex_q.rs1;
  assign rf_read_reg2 = adv ? rs2_f : ex_q.rs2;

  always_comb begin
    ex_d      = ex_q;
    illegal_d = 1'b0;
    if (adv) begin
      ex_d       = dec;
      ex_d.valid = !flush && !hz && if_valid && legal;
      illegal_d  = !flush && !hz && if_valid && !legal;
    end else if (flush) begin
      ex_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ex_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      ex_q      <= ex_d;
      illegal_q <= illegal_d;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_rs1       = ex_q.rs1;
  assign ex_rs2       = ex_q.rs2;
  assign ex_rd        = ex_q.rd;
  assign ex_imm       = ex_q.imm;
  assign ex_alu_op    = ex_q.alu_op;
  assign ex_funct3    = ex_q.funct3;
  assign ex_alu_src   = ex_q.alu_src;
  assign ex_mem_read  = ex_q.mem_read;
  assign ex_mem_write = ex_q.mem_write;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_branch    = ex_q.branch;
  assign illegal      = illegal_q;
  assign ex_rs1_data  = (ex_q.rs1 == '0) ? '0 : op1;
  assign ex_rs2_data  = (ex_q.rs2 == '0) ? '0 : op2;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed checks of decode_stage against a registered-read RF model.
// Bypass-dependent expectations follow WB_BYPASS_EN.
module tb_decode_stage;

  localparam logic [31:0] ADDI_X1 = 32'h0050_0093;
  localparam logic [31:0] ADD_X2  = 32'h0010_8133;
  localparam logic [31:0] LW_X3   = 32'h0000_2183;
  localparam logic [31:0] ADD_X4  = 32'h0001_8233;
  localparam logic [31:0] ADD_X7  = 32'h0002_83B3;
  localparam logic [31:0] ADD_X8  = 32'h0003_0433;
  localparam logic [31:0] SUB_X11 = 32'h4020_85B3;
  localparam logic [31:0] SRAI    = 32'h4030_D513;
  localparam logic [31:0] SW      = 32'hFE20_AEA3;
  localparam logic [31:0] BEQ     = 32'h0020_8463;
  localparam logic [31:0] BAD_OP  = 32'h0000_007F;
  localparam logic [31:0] ADD_X9  = 32'h0000_04B3;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_valid;
  logic [31:0] if_instr;
  logic        if_ready;
  logic        flush;
  logic [4:0]  rf_read_reg1;
  logic [4:0]  rf_read_reg2;
  logic [7:0]  rf_read_data1;
  logic [7:0]  rf_read_data2;
  logic        wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic [7:0]  wb_write_data;
  logic        ex_ready;
  logic        ex_valid;
  logic [7:0]  ex_rs1_data;
  logic [7:0]  ex_rs2_data;
  logic [7:0]  ex_imm;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  logic [4:0]  ex_rd;
  logic [3:0]  ex_alu_op;
  logic [2:0]  ex_funct3;
  logic        ex_alu_src;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_reg_write;
  logic        ex_branch;
  logic        illegal;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mem [32];

  always #5 clock = ~clock;

  // register file: registered read, old data on a same-edge write
  always @(posedge clock) begin
    if (wb_reg_write) mem[wb_write_reg] <= wb_write_data;
    rf_read_data1 <= mem[rf_read_reg1];
    rf_read_data2 <= mem[rf_read_reg2];
  end

  decode_stage #(.DATA_W(8), .REG_AW(5)) dut (
    .clock(clock), .reset(reset),
    .if_valid(if_valid), .if_instr(if_instr), .if_ready(if_ready),
    .flush(flush),
    .rf_read_reg1(rf_read_reg1), .rf_read_reg2(rf_read_reg2),
    .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
    .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
    .wb_write_data(wb_write_data),
    .ex_ready(ex_ready), .ex_valid(ex_valid),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_alu_op(ex_alu_op), .ex_funct3(ex_funct3),
    .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_branch(ex_branch), .illegal(illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wb(input logic [4:0] r, input logic [7:0] d);
    wb_reg_write  = 1'b1;
    wb_write_reg  = r;
    wb_write_data = d;
  endtask

  task automatic issue(input logic [31:0] ins);
    if_valid = 1'b1;
    if_instr = ins;
  endtask

  initial begin
    reset = 1'b1; if_valid = 1'b0; if_instr = '0; flush = 1'b0;
    ex_ready = 1'b1; wb_reg_write = 1'b0; wb_write_reg = '0;
    wb_write_data = '0;

    // preload x1, x2, x6 while in reset
    wb(5'd1, 8'h11); tick();
    wb(5'd2, 8'h22); tick();
    wb(5'd6, 8'h55); tick();
    wb_reg_write = 1'b0; tick();
    chk("rst_valid", 32'(ex_valid), 0);
    chk("rst_imm", 32'(ex_imm), 0);
    chk("rst_rd", 32'(ex_rd), 0);
    chk("rst_illegal", 32'(illegal), 0);
    reset = 1'b0; #1;
    chk("rst_ready", 32'(if_ready), 1);

    // addi x1,x0,5
    issue(ADDI_X1); #1;
    chk("addi_raddr", 32'(rf_read_reg1), 0);
    tick();
    chk("addi_valid", 32'(ex_valid), 1);
    chk("addi_rd", 32'(ex_rd), 1);
    chk("addi_op", 32'(ex_alu_op), 0);
    chk("addi_src", 32'(ex_alu_src), 1);
    chk("addi_imm", 32'(ex_imm), 5);
    chk("addi_d1", 32'(ex_rs1_data), 0);

    // add x2,x1,x1
    issue(ADD_X2); tick();
    chk("add_rs1", 32'(ex_rs1), 1);
    chk("add_rs2", 32'(ex_rs2), 1);
    chk("add_op", 32'(ex_alu_op), 0);
    chk("add_rd", 32'(ex_rd), 2);
    chk("add_d1", 32'(ex_rs1_data), 32'h11);
    chk("add_d2", 32'(ex_rs2_data), 32'h11);

    // lw x3 then dependent add x4,x3,x0
    issue(LW_X3); tick();
    chk("lw_valid", 32'(ex_valid), 1);
    chk("lw_mrd", 32'(ex_mem_read), 1);
    chk("lw_f3", 32'(ex_funct3), 2);
    chk("lw_rd", 32'(ex_rd), 3);
    issue(ADD_X4); #1;
    chk("lu_ready", 32'(if_ready), 0);
    tick();
    chk("lu_bubble", 32'(ex_valid), 0);
    chk("lu_ready2", 32'(if_ready), 1);
    tick();
    chk("lu_valid", 32'(ex_valid), 1);
    chk("lu_rd", 32'(ex_rd), 4);
    chk("lu_rs1", 32'(ex_rs1), 3);

    // writeback to x5 on the edge that reads x5
    issue(ADD_X7); wb(5'd5, 8'hA7); #1;
`ifdef WB_BYPASS_EN
    chk("wb_ready", 32'(if_ready), 1);
    tick(); wb_reg_write = 1'b0;
    chk("wb_valid", 32'(ex_valid), 1);
    chk("wb_d1", 32'(ex_rs1_data), 32'hA7);
`else
    chk("wb_ready", 32'(if_ready), 0);
    tick(); wb_reg_write = 1'b0; #1;
    chk("wb_bubble", 32'(ex_valid), 0);
    chk("wb_ready2", 32'(if_ready), 1);
    tick();
    chk("wb_valid", 32'(ex_valid), 1);
    chk("wb_d1", 32'(ex_rs1_data), 32'hA7);
`endif

    // EX stall for 3 cycles while x6 is rewritten
    issue(ADD_X8); tick();
    chk("st_d1_old", 32'(ex_rs1_data), 32'h55);
    ex_ready = 1'b0; issue(SUB_X11); wb(5'd6, 8'h3C); #1;
    chk("st_ready", 32'(if_ready), 0);
    chk("st_raddr", 32'(rf_read_reg1), 6);
    tick(); wb_reg_write = 1'b0;
    tick(); tick();
    chk("st_d1_new", 32'(ex_rs1_data), 32'h3C);
    chk("st_valid", 32'(ex_valid), 1);
    chk("st_rd", 32'(ex_rd), 8);
    chk("st_rs1", 32'(ex_rs1), 6);
    chk("st_op", 32'(ex_alu_op), 0);
    chk("st_imm", 32'(ex_imm), 0);
    ex_ready = 1'b1; #1;
    chk("st_ready2", 32'(if_ready), 1);
    tick();
    chk("sub_op", 32'(ex_alu_op), 32'h8);
    chk("sub_rd", 32'(ex_rd), 11);
    chk("sub_d1", 32'(ex_rs1_data), 32'h11);
    chk("sub_d2", 32'(ex_rs2_data), 32'h22);

    // srai and sw immediates
    issue(SRAI); tick();
    chk("srai_op", 32'(ex_alu_op), 32'hD);
    chk("srai_imm", 32'(ex_imm), 3);
    chk("srai_rd", 32'(ex_rd), 10);
    issue(SW); tick();
    chk("sw_mwr", 32'(ex_mem_write), 1);
    chk("sw_rd", 32'(ex_rd), 0);
    chk("sw_imm", 32'(ex_imm), 32'hFD);
    chk("sw_d2", 32'(ex_rs2_data), 32'h22);

    // flush kills beq, then beq again
    issue(BEQ); flush = 1'b1; #1;
    chk("fl_ready", 32'(if_ready), 1);
    tick(); flush = 1'b0;
    chk("fl_valid", 32'(ex_valid), 0);
    chk("fl_illegal", 32'(illegal), 0);
    tick();
    chk("beq_valid", 32'(ex_valid), 1);
    chk("beq_br", 32'(ex_branch), 1);
    chk("beq_op", 32'(ex_alu_op), 32'h8);
    chk("beq_imm", 32'(ex_imm), 8);
    chk("beq_rd", 32'(ex_rd), 0);

    // unsupported opcode
    issue(BAD_OP); tick();
    chk("ill_pulse", 32'(illegal), 1);
    chk("ill_valid", 32'(ex_valid), 0);
    if_valid = 1'b0; tick();
    chk("ill_clear", 32'(illegal), 0);

    // flush while stalled, then reset while stalled
    issue(LW_X3); tick();
    chk("sl_valid", 32'(ex_valid), 1);
    ex_ready = 1'b0; issue(ADD_X4); #1;
    chk("sl_ready", 32'(if_ready), 0);
    tick();
    chk("sl_held", 32'(ex_rd), 3);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("sfl_valid", 32'(ex_valid), 0);
    issue(LW_X3); tick();
    tick();
    chk("rs_held", 32'(ex_valid), 1);
    reset = 1'b1; if_valid = 1'b0; tick();
    chk("rs_valid", 32'(ex_valid), 0);
    chk("rs_rd", 32'(ex_rd), 0);
    chk("rs_mrd", 32'(ex_mem_read), 0);
    chk("rs_f3", 32'(ex_funct3), 0);
    reset = 1'b0; ex_ready = 1'b1; #1;
    chk("rs_ready", 32'(if_ready), 1);

    // x0 always reads as zero
    wb(5'd0, 8'hFF); tick(); wb_reg_write = 1'b0;
    issue(ADD_X9); tick();
    chk("x0_valid", 32'(ex_valid), 1);
    chk("x0_d1", 32'(ex_rs1_data), 0);
    chk("x0_d2", 32'(ex_rs2_data), 0);
    chk("x0_rd", 32'(ex_rd), 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
